// File: rtl/init_cmd_issuer.sv
// init_cmd_issuer
// Once the upstream ready flag is seen high, issues a fixed burst of NUM_CMDS
// configuration commands (address k, data DATA_SEED + k) over a valid/ready
// handshake, then raises a sticky done. A drop of ready_in mid-burst parks the
// block in PAUSE after the pending command is accepted.
//
// Ports:
//   clk        in   sole clock, posedge
//   rst        in   asynchronous active-high reset
//   ready_in   in   upstream readiness flag
//   cmd_valid  out  command valid (registered)
//   cmd_ready  in   downstream accept
//   cmd_addr   out  command index k (registered)
//   cmd_data   out  DATA_SEED + k mod 2**DATA_W (registered)
//   busy       out  high while in ISSUE or PAUSE (registered)
//   done       out  sticky completion flag, cleared only by rst (registered)
//
// Optional build macro: INIT_CMD_ISSUER_SVA_EN embeds the formal property set.
module init_cmd_issuer #(
    parameter int unsigned       NUM_CMDS  = 8,
    parameter int unsigned       ADDR_W    = 4,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] DATA_SEED = 8'hA0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready_in,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_CMDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_PAUSE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                hs;

    // State and output registers; addr_q doubles as the command counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= DATA_SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        hs      = valid_q & cmd_ready;

        unique case (state_q)
            S_IDLE: begin
                if (ready_in) begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                // valid stays up regardless of ready_in until the handshake
                if (hs) begin
                    if (addr_q == LAST_K) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // data tracks DATA_SEED + k by stepping with the counter
                        addr_d  = addr_q + ADDR_W'(1);
                        data_d  = data_q + DATA_W'(1);
                        if (ready_in) begin
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_PAUSE;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (ready_in) begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                end
            end
            S_DONE: begin
                // terminal until rst
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign cmd_valid = valid_q;
    assign cmd_addr  = addr_q;
    assign cmd_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef INIT_CMD_ISSUER_SVA_EN
    // Formal-only: start every trace from reset.
    initial assume (rst);

    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
        cmd_valid && !cmd_ready |=> cmd_valid);

    a_payload_hold: assert property (@(posedge clk) disable iff (rst)
        cmd_valid && !cmd_ready |=> $stable(cmd_addr) && $stable(cmd_data));

    a_done_quiet: assert property (@(posedge clk) disable iff (rst)
        done |-> !cmd_valid && !busy);

    a_done_sticky: assert property (@(posedge clk) disable iff (rst)
        done |=> done);

    a_addr_range: assert property (@(posedge clk) disable iff (rst)
        32'(cmd_addr) < 32'(NUM_CMDS));

    c_done: cover property (@(posedge clk) disable iff (rst) done);
`endif

endmodule

// File: tb/tb_init_cmd_issuer.sv
// Scoreboard bench for init_cmd_issuer: a default instance (8 commands, seed A0)
// and a small instance (4 commands, seed FE) for the data wrap.
module tb_init_cmd_issuer;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic          ready_in,  cmd_ready;
    logic          cmd_valid, busy, done;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;

    logic          ready_in2,  cmd_ready2;
    logic          cmd_valid2, busy2, done2;
    logic [AW-1:0] cmd_addr2;
    logic [DW-1:0] cmd_data2;

    logic [AW+DW-1:0] exp_q  [$];
    logic [AW+DW-1:0] exp_q2 [$];

    int n_vec;
    int n_err;

    init_cmd_issuer #(.NUM_CMDS(8), .ADDR_W(AW), .DATA_W(DW), .DATA_SEED(8'hA0)) u_dut (
        .clk(clk), .rst(rst), .ready_in(ready_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .busy(busy), .done(done)
    );

    init_cmd_issuer #(.NUM_CMDS(4), .ADDR_W(AW), .DATA_W(DW), .DATA_SEED(8'hFE)) u_dut_wrap (
        .clk(clk), .rst(rst), .ready_in(ready_in2),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_addr(cmd_addr2), .cmd_data(cmd_data2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are seen at negedge, ahead of the edge that accepts them.
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_hs", 32'({cmd_addr, cmd_data}), 32'hFFFF);
            end else begin
                check("hs_payload", 32'({cmd_addr, cmd_data}), 32'(exp_q.pop_front()));
            end
        end
        if (cmd_valid2 && cmd_ready2) begin
            if (exp_q2.size() == 0) begin
                check("unexpected_hs2", 32'({cmd_addr2, cmd_data2}), 32'hFFFF);
            end else begin
                check("hs_payload2", 32'({cmd_addr2, cmd_data2}), 32'(exp_q2.pop_front()));
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_addr"},  32'(cmd_addr),  32'd0);
        check({tag, "_data"},  32'(cmd_data),  32'hA0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    task automatic push_burst();
        for (int k = 0; k < 8; k++) begin
            logic [DW-1:0] d;
            d = DW'(8'hA0 + k);
            exp_q.push_back({AW'(k), d});
        end
    endtask

    // Uninterrupted burst from IDLE with both flags held high.
    task automatic run_burst(input string tag);
        push_burst();
        ready_in  = 1'b1;
        cmd_ready = 1'b1;
        tick();
        check({tag, "_start_valid"}, 32'(cmd_valid), 32'd1);
        check({tag, "_start_addr"},  32'(cmd_addr),  32'd0);
        check({tag, "_start_busy"},  32'(busy),      32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7) begin
                check({tag, "_b2b_valid"}, 32'(cmd_valid), 32'd1);
                check({tag, "_b2b_addr"},  32'(cmd_addr),  32'(i + 1));
                check({tag, "_b2b_done"},  32'(done),      32'd0);
            end
        end
        check({tag, "_done"},      32'(done),      32'd1);
        check({tag, "_end_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_end_busy"},  32'(busy),      32'd0);
        check({tag, "_q_empty"},   32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        ready_in   = 1'b0;
        cmd_ready  = 1'b0;
        ready_in2  = 1'b0;
        cmd_ready2 = 1'b0;
        tick();
        tick();
        check_reset("rst");
        rst = 1'b0;
        tick();
        tick();
        check("idle_valid", 32'(cmd_valid), 32'd0);
        check("idle_busy",  32'(busy),      32'd0);

        // Full burst with no stalls.
        run_burst("b1");

        rst = 1'b1;
        #1;
        check_reset("rst_after_done");
        tick();
        rst       = 1'b0;
        ready_in  = 1'b0;
        cmd_ready = 1'b0;
        tick();

        // Backpressure at k=2, ready_in drop at k=4, resume, then rst at k=5.
        push_burst();
        ready_in  = 1'b1;
        cmd_ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_addr_pre", 32'(cmd_addr), 32'd2);
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 32'(cmd_valid), 32'd1);
            check("bp_addr",  32'(cmd_addr),  32'd2);
            check("bp_data",  32'(cmd_data),  32'hA2);
        end
        cmd_ready = 1'b1;
        tick();
        check("bp_accept_addr", 32'(cmd_addr), 32'd3);
        tick();
        check("k4_addr", 32'(cmd_addr), 32'd4);
        ready_in  = 1'b0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("drop_valid", 32'(cmd_valid), 32'd1);
            check("drop_addr",  32'(cmd_addr),  32'd4);
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_valid", 32'(cmd_valid), 32'd0);
            check("pause_busy",  32'(busy),      32'd1);
            check("pause_addr",  32'(cmd_addr),  32'd5);
        end
        ready_in = 1'b1;
        tick();
        check("resume_valid", 32'(cmd_valid), 32'd1);
        check("resume_addr",  32'(cmd_addr),  32'd5);
        check("resume_data",  32'(cmd_data),  32'hA5);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        exp_q.delete();
        tick();
        rst       = 1'b0;
        ready_in  = 1'b0;
        cmd_ready = 1'b0;

        // Restart after the aborted burst begins again at k=0.
        run_burst("b2");

        // Done is terminal under arbitrary input activity.
        for (int i = 0; i < 20; i++) begin
            ready_in  = 1'($urandom_range(0, 1));
            cmd_ready = 1'($urandom_range(0, 1));
            tick();
            check("post_done", 32'(done),      32'd1);
            check("post_valid", 32'(cmd_valid), 32'd0);
        end
        ready_in  = 1'b0;
        cmd_ready = 1'b0;

        // Seed FE wraps through FF to 00, 01.
        for (int k = 0; k < 4; k++) begin
            logic [DW-1:0] d;
            d = DW'(8'hFE + k);
            exp_q2.push_back({AW'(k), d});
        end
        check("wrap_rst_data", 32'(cmd_data2), 32'hFE);
        ready_in2  = 1'b1;
        cmd_ready2 = 1'b1;
        tick();
        check("wrap_start_valid", 32'(cmd_valid2), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("wrap_done",     32'(done2),        32'd1);
        check("wrap_valid",    32'(cmd_valid2),   32'd0);
        check("wrap_q_empty",  32'(exp_q2.size()), 32'd0);
        check("main_q_empty",  32'(exp_q.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
